alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execution end of the ALU-control interface: consumes the 4-bit alu_ctrl code produced by the control decoder plus two operands, and produces the result.
- Logic, add/sub, shift, LUI and branch-compare ops complete in one cycle.
- MUL and DIV run iteratively over DATA_WIDTH cycles.
- Sits in the EX stage behind a valid/ready handshake so the pipeline can stall on multi-cycle ops.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and >= 8.
- CTRL_WIDTH, 4, alu_ctrl width; must equal the shared `CTRL_WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request.
- alu_ctrl  input  CTRL_WIDTH  operation code.
- op_a  input  DATA_WIDTH  first operand (rs).
- op_b  input  DATA_WIDTH  second operand (rt/immediate; shift amount in low log2(DATA_WIDTH) bits).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  DATA_WIDTH  primary result (quotient for DIV, low product for MUL).
- result_hi  output  DATA_WIDTH  remainder for DIV, high product for MUL, 0 otherwise.
- zero  output  1  result == 0.
- branch_taken  output  1  compare outcome for codes 1100-1111, 0 otherwise.
- div_by_zero  output  1  DIV issued with op_b == 0.

Behaviour:
- Reset (asynchronous, any state, including mid-iteration):
  - State goes to IDLE.
  - in_ready=1, out_valid=0.
  - result, result_hi, zero, branch_taken and div_by_zero are all 0.
  - Iteration counter is cleared.
- Opcode semantics:
  - 0000 AND, 0001 OR, 0010 ADD (wraps mod 2^DATA_WIDTH), 0011 XOR, 0100 NOR, 0110 SUB (a-b, wraps).
  - 0101 MUL: unsigned, 2*DATA_WIDTH product.
  - 0111 DIV: unsigned, quotient and remainder.
  - 1000 SLL, 1001 SRL, 1010 SRA: each shifts op_a by op_b[log2(DATA_WIDTH)-1:0].
  - 1011 LUI: result = op_b << (DATA_WIDTH/2).
  - 1100 BEQ (a==b), 1101 BNE (a!=b), 1110 BLT (signed a<b), 1111 BLE (signed a<=b). result = {0..,branch_taken}.
- FSM states: IDLE, MUL, DIV, DONE.
  - in_ready=1 only in IDLE. Accept = in_valid && in_ready; alu_ctrl and operands are captured at accept.
  - IDLE, single-cycle op accepted: compute and register outputs, go to DONE. out_valid is high the cycle after accept (latency 1).
  - IDLE, MUL accepted: shift-add, one bit per cycle, DATA_WIDTH iterations, then DONE. out_valid rises DATA_WIDTH+1 cycles after accept.
  - IDLE, DIV accepted: restoring division, one quotient bit per cycle, DATA_WIDTH iterations, then DONE. Same latency as MUL.
  - DIV with op_b==0: skip iteration and go straight to DONE (latency 1). result=all ones, result_hi=op_a, div_by_zero=1.
  - DONE: out_valid=1. Outputs are held stable until out_ready. On out_valid && out_ready, go to IDLE and drop out_valid the next cycle.
- No same-cycle back-to-back issue: the next accept is at the earliest one cycle after the result handoff.
- in_valid while busy is ignored; the requester holds its request.
- Operand changes after accept have no effect.
- zero is computed on result only. div_by_zero is cleared on the next accept.
- Undefined codes cannot occur; all 16 codes are defined.

Decomposition:
- Shared config.v holds:
  - `CTRL_WIDTH.
  - Named alu_ctrl codes (`ALU_AND … `ALU_BLE), which the control decoder shares.
  - FSM state encodings.
- One sub-module, alu_muldiv_iter:
  - Holds the shared accumulator/shift register and counter for MUL and DIV.
  - Interface: start, is_div, a, b, done, lo, hi.
- Single-cycle datapath stays in the top module.

Test Plan:
- ADD 0x7FFFFFFF+1 -> result 0x80000000, zero 0, out_valid one cycle after accept. ADD 0xFFFFFFFF+1 -> result 0, zero 1.
- SRA 0x80000000 by 4 -> 0xF8000000. SRL same -> 0x08000000. LUI op_b=0x1234 -> 0x12340000.
- BLT 0xFFFFFFFF vs 1 -> branch_taken 1. BLE 5 vs 5 -> 1. BNE 5 vs 5 -> 0. result equals {0,branch_taken} in each case.
- MUL 0xFFFFFFFF*0xFFFFFFFF -> result 0x00000001, result_hi 0xFFFFFFFE. out_valid exactly 33 cycles after accept, in_ready low throughout.
- DIV 100/7 -> result 14, result_hi 2 after 33 cycles. DIV 9/0 -> result 0xFFFFFFFF, result_hi 9, div_by_zero 1 one cycle after accept.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, no new accept.
  - Assert rst_n=0 at MUL iteration 10 -> immediately in_ready=1 and out_valid=0.
  - Fresh ADD after reset -> correct result.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit shared definitions: alu_ctrl width, named
// operation codes and EX-stage FSM state encoding.
package alu_exec_unit_pkg;

  localparam int ALU_CTRL_W = 4;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_NOR = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_DIV = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_LUI = 4'b1011;
  localparam logic [3:0] ALU_BEQ = 4'b1100;
  localparam logic [3:0] ALU_BNE = 4'b1101;
  localparam logic [3:0] ALU_BLT = 4'b1110;
  localparam logic [3:0] ALU_BLE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_exec_unit_muldiv.sv
// alu_muldiv_iter: shared shift register + counter for unsigned MUL
// (shift-add) and DIV (restoring). Ports: clk, rst_n, start, is_div,
// a, b in; done (1-cycle pulse once lo/hi are final), lo, hi out.
module alu_muldiv_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_m;
  logic          r_div;
  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] r_cnt;

  logic [W-1:0]  w_cur_lo;
  logic [W-1:0]  w_cur_hi;
  logic [W-1:0]  w_cur_m;
  logic          w_cur_div;
  logic [W:0]    w_sum;
  logic [W:0]    w_sh;
  logic          w_ge;
  logic [W-1:0]  w_diff;
  logic [W-1:0]  w_nxt_lo;
  logic [W-1:0]  w_nxt_hi;
  logic          w_step;
  logic          w_last;

  // The first step is folded into the start cycle so the
  // final value lands one cycle before the top registers it.
  always_comb begin
    w_cur_lo  = start ? a : r_lo;
    w_cur_hi  = start ? '0 : r_hi;
    w_cur_m   = start ? b : r_m;
    w_cur_div = start ? is_div : r_div;
  end

  always_comb begin
    w_sum = {1'b0, w_cur_hi}
          + (w_cur_lo[0] ? {1'b0, w_cur_m} : '0);
    w_sh  = {w_cur_hi, w_cur_lo[W-1]};
    w_ge  = (w_sh >= {1'b0, w_cur_m});
    // remainder stays below divisor, so W bits suffice
    w_diff = w_sh[W-1:0] - w_cur_m;
    if (w_cur_div) begin
      w_nxt_hi = w_ge ? w_diff : w_sh[W-1:0];
      w_nxt_lo = {w_cur_lo[W-2:0], w_ge};
    end else begin
      w_nxt_hi = w_sum[W:1];
      w_nxt_lo = {w_sum[0], w_cur_lo[W-1:1]};
    end
  end

  assign w_step = start | r_busy;
  assign w_last = r_busy & (r_cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo   <= '0;
      r_hi   <= '0;
      r_m    <= '0;
      r_div  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= w_last;
      if (w_step) begin
        r_lo <= w_nxt_lo;
        r_hi <= w_nxt_hi;
      end
      if (start) begin
        r_m    <= b;
        r_div  <= is_div;
        r_busy <= 1'b1;
        r_cnt  <= CW'(1);
      end else if (r_busy) begin
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_busy <= 1'b0;
          r_cnt  <= '0;
        end
      end
    end
  end

  assign done = r_done;
  assign lo   = r_lo;
  assign hi   = r_hi;

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU behind valid/ready. Single-cycle ops
// return next cycle; MUL/DIV iterate DATA_WIDTH cycles in
// alu_muldiv_iter. Outputs: in_ready, out_valid, result, result_hi,
// zero, branch_taken, div_by_zero (all registered).
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = ALU_CTRL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] alu_ctrl,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  zero,
  output logic                  branch_taken,
  output logic                  div_by_zero
);

  localparam int SW = $clog2(DATA_WIDTH);

  state_e                r_state;
  logic [DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH-1:0] r_hi;
  logic                  r_zero;
  logic                  r_br;
  logic                  r_dbz;

  logic                  w_accept;
  logic                  w_is_mul;
  logic                  w_is_div;
  logic                  w_b_zero;
  logic                  w_start;
  logic [SW-1:0]         w_shamt;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_br;
  logic                  w_it_done;
  logic [DATA_WIDTH-1:0] w_it_lo;
  logic [DATA_WIDTH-1:0] w_it_hi;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign w_accept  = in_valid & in_ready;
  assign w_is_mul  = (alu_ctrl == ALU_MUL);
  assign w_is_div  = (alu_ctrl == ALU_DIV);
  assign w_b_zero  = (op_b == '0);
  assign w_shamt   = op_b[SW-1:0];
  // DIV by zero never enters the iterator
  assign w_start   = w_accept
                   & (w_is_mul | (w_is_div & ~w_b_zero));

  always_comb begin
    w_res = '0;
    w_br  = 1'b0;
    unique case (alu_ctrl)
      ALU_AND: w_res = op_a & op_b;
      ALU_OR:  w_res = op_a | op_b;
      ALU_ADD: w_res = op_a + op_b;
      ALU_XOR: w_res = op_a ^ op_b;
      ALU_NOR: w_res = ~(op_a | op_b);
      ALU_SUB: w_res = op_a - op_b;
      ALU_MUL, ALU_DIV: w_res = '0;
      ALU_SLL: w_res = op_a << w_shamt;
      ALU_SRL: w_res = op_a >> w_shamt;
      ALU_SRA: w_res = $signed(op_a) >>> w_shamt;
      ALU_LUI: w_res = op_b << (DATA_WIDTH / 2);
      ALU_BEQ: w_br = (op_a == op_b);
      ALU_BNE: w_br = (op_a != op_b);
      ALU_BLT: w_br = ($signed(op_a) < $signed(op_b));
      ALU_BLE: w_br = ($signed(op_a) <= $signed(op_b));
      default: w_res = '0;
    endcase
    // compare codes report the outcome in bit 0
    w_res = w_res | DATA_WIDTH'(w_br);
  end

  alu_muldiv_iter #(
    .W(DATA_WIDTH)
  ) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .is_div(w_is_div),
    .a     (op_a),
    .b     (op_b),
    .done  (w_it_done),
    .lo    (w_it_lo),
    .hi    (w_it_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_hi     <= '0;
      r_zero   <= 1'b0;
      r_br     <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_dbz <= 1'b0;
            r_br  <= 1'b0;
            if (w_is_mul) begin
              r_state <= ST_MUL;
            end else if (w_is_div && !w_b_zero) begin
              r_state <= ST_DIV;
            end else if (w_is_div) begin
              r_result <= '1;
              r_hi     <= op_a;
              r_zero   <= 1'b0;
              r_dbz    <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_result <= w_res;
              r_hi     <= '0;
              r_zero   <= (w_res == '0);
              r_br     <= w_br;
              r_state  <= ST_DONE;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (w_it_done) begin
            r_result <= w_it_lo;
            r_hi     <= w_it_hi;
            r_zero   <= (w_it_lo == '0);
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign result       = r_result;
  assign result_hi    = r_hi;
  assign zero         = r_zero;
  assign branch_taken = r_br;
  assign div_by_zero  = r_dbz;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: queue-based reference
// model, per-cycle output compare, directed + random stimulus.
module tb_alu_exec_unit;

  localparam int W = 32;

  localparam logic [3:0] C_AND = 4'h0;
  localparam logic [3:0] C_ADD = 4'h2;
  localparam logic [3:0] C_MUL = 4'h5;
  localparam logic [3:0] C_SUB = 4'h6;
  localparam logic [3:0] C_DIV = 4'h7;
  localparam logic [3:0] C_SRL = 4'h9;
  localparam logic [3:0] C_SRA = 4'hA;
  localparam logic [3:0] C_LUI = 4'hB;
  localparam logic [3:0] C_BNE = 4'hD;
  localparam logic [3:0] C_BLT = 4'hE;
  localparam logic [3:0] C_BLE = 4'hF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alu_ctrl = '0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         branch_taken;
  logic         div_by_zero;

  always #5 clk = ~clk;

  alu_exec_unit #(.DATA_WIDTH(W), .CTRL_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi),
    .zero(zero), .branch_taken(branch_taken),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         br;
    logic         dbz;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   seen = 1'b0;
  int   hold_n = 0;
  bit   rnd_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the operation's meaning.
  function automatic exp_t model(input logic [3:0] c,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] p;
    int sh;
    e.res = '0; e.hi = '0; e.br = 1'b0; e.dbz = 1'b0;
    e.lat = 1; e.acc = 0;
    sh = int'(b % W);
    p = 64'(a) * 64'(b);
    case (c)
      4'h0: e.res = a & b;
      4'h1: e.res = a | b;
      4'h2: e.res = a + b;
      4'h3: e.res = a ^ b;
      4'h4: e.res = ~(a | b);
      4'h5: begin
        e.res = p[W-1:0]; e.hi = p[2*W-1:W]; e.lat = W + 1;
      end
      4'h6: e.res = a - b;
      4'h7: begin
        if (b == 0) begin
          e.res = '1; e.hi = a; e.dbz = 1'b1;
        end else begin
          e.res = a / b; e.hi = a % b; e.lat = W + 1;
        end
      end
      4'h8: e.res = a << sh;
      4'h9: e.res = a >> sh;
      4'hA: e.res = $unsigned($signed(a) >>> sh);
      4'hB: e.res = b << (W / 2);
      4'hC: e.br = (a == b);
      4'hD: e.br = (a != b);
      4'hE: e.br = ($signed(a) < $signed(b));
      default: e.br = ($signed(a) <= $signed(b));
    endcase
    if (c >= 4'hC) e.res = W'(e.br);
    return e;
  endfunction

  // Single compare process: every cycle out_valid is high.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      seen = 1'b0;
      out_ready = 1'b0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL spurious_valid: got 1 expected 0");
      end else begin
        chk("result", result, q[0].res);
        chk("result_hi", result_hi, q[0].hi);
        chk("zero", W'(zero), W'(q[0].res == 0));
        chk("branch", W'(branch_taken), W'(q[0].br));
        chk("dbz", W'(div_by_zero), W'(q[0].dbz));
        chk("ready_in_done", W'(in_ready), '0);
        if (!seen) begin
          chk("latency", W'(cyc - q[0].acc), W'(q[0].lat));
          seen = 1'b1;
        end
        if (hold_n > 0) begin
          out_ready = 1'b0;
          hold_n--;
        end else begin
          out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (out_ready) begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end else begin
      if (q.size() > 0 && q[0].acc != cyc)
        chk("ready_busy", W'(in_ready), '0);
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic issue(input logic [3:0] c,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    exp_t e;
    int g;
    g = 0;
    @(negedge clk);
    alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: got 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    e = model(c, a, b);
    e.acc = cyc;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    alu_ctrl = 4'($urandom);
    op_a = $urandom;
    op_b = $urandom;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() > 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (q.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: got %0d expected 0", q.size());
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    chk({tag, "_out_valid"}, W'(out_valid), '0);
    chk({tag, "_result"}, result, '0);
    chk({tag, "_result_hi"}, result_hi, '0);
    chk({tag, "_zero"}, W'(zero), '0);
    chk({tag, "_branch"}, W'(branch_taken), '0);
    chk({tag, "_dbz"}, W'(div_by_zero), '0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    exp_t e;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    #2 rst_n = 1'b1;

    e = model(C_ADD, 32'h7FFF_FFFF, 32'h1);
    chk("pin_add_ovf", e.res, 32'h8000_0000);
    e = model(C_ADD, 32'hFFFF_FFFF, 32'h1);
    chk("pin_add_wrap", e.res, 32'h0);
    e = model(C_SRA, 32'h8000_0000, 32'd4);
    chk("pin_sra", e.res, 32'hF800_0000);
    e = model(C_SRL, 32'h8000_0000, 32'd4);
    chk("pin_srl", e.res, 32'h0800_0000);
    e = model(C_LUI, 32'h0, 32'h1234);
    chk("pin_lui", e.res, 32'h1234_0000);
    e = model(C_BLT, 32'hFFFF_FFFF, 32'h1);
    chk("pin_blt", e.res, 32'h1);
    e = model(C_BNE, 32'd5, 32'd5);
    chk("pin_bne", e.res, 32'h0);
    e = model(C_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("pin_mul_lo", e.res, 32'h1);
    chk("pin_mul_hi", e.hi, 32'hFFFF_FFFE);
    e = model(C_DIV, 32'd100, 32'd7);
    chk("pin_div_q", e.res, 32'd14);
    chk("pin_div_r", e.hi, 32'd2);
    e = model(C_DIV, 32'd9, 32'd0);
    chk("pin_div0", e.res, 32'hFFFF_FFFF);
    chk("pin_div0_lat", W'(e.lat), W'(1));

    issue(C_ADD, 32'h7FFF_FFFF, 32'h1);
    issue(C_ADD, 32'hFFFF_FFFF, 32'h1);
    issue(C_SRA, 32'h8000_0000, 32'd4);
    issue(C_SRL, 32'h8000_0000, 32'd4);
    issue(C_LUI, 32'h0, 32'h1234);
    issue(C_BLT, 32'hFFFF_FFFF, 32'h1);
    issue(C_BLE, 32'd5, 32'd5);
    issue(C_BNE, 32'd5, 32'd5);
    issue(C_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(C_DIV, 32'd100, 32'd7);
    issue(C_DIV, 32'd9, 32'd0);
    issue(C_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
    drain();

    hold_n = 5;
    issue(C_ADD, 32'd3, 32'd4);
    issue(C_SUB, 32'd3, 32'd4);
    drain();

    issue(C_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_mid_mul");
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    issue(C_ADD, 32'd12345, 32'd54321);
    drain();

    rnd_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick());
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
